// File: rtl/ow_apb_bridge.sv
// APB3 slave bridging a CPU to the One-Wire PHY through TX/RX byte FIFOs; optional irq via OW_APB_IRQ_EN.
// Latency: register writes/pops commit on the edge ending the access; wr_phy_fifo_empty and irq lag state by one cycle.
// Backpressure: zero wait states; a full TX FIFO or empty RX FIFO answers with pslverr; a full RX FIFO drops PHY bytes and sets rx_ovf.

// Generic show-ahead byte FIFO with synchronous flush.
// Latency: a pushed entry is visible at the head the cycle after the push edge.
// Backpressure: push while full is dropped unless a pop frees a slot in the same cycle; pop while empty is ignored.
module ow_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic push_ok;
    logic pop_ok;

    // Pop needs data; push needs a slot, which a same-cycle pop provides.
    always_comb begin
        empty    = (level == '0);
        full     = (level == (AW+1)'(DEPTH));
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        head_dat = mem[rp];
    end

    // Pointer and level bookkeeping; flush overrides any concurrent push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop_ok)  rp <= rp + 1'b1;
            if (push_ok && !pop_ok)      level <= level + 1'b1;
            else if (!push_ok && pop_ok) level <= level - 1'b1;
        end
    end

    // Storage array; contents are meaningless whenever level is 0, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wp] <= push_dat;
    end
endmodule

module ow_apb_bridge #(
    parameter int PHY_FIFO_WIDTH = 8,
    parameter int FIFO_DEPTH     = 16,
    parameter int FIFO_AW        = 4,
    parameter int APB_AW         = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [APB_AW-1:0]         paddr,
    input  logic [31:0]               pwdata,
    output logic [31:0]               prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic                      wr_phy_fifo_empty,
    input  logic                      wr_phy_fifo_en,
    output logic [PHY_FIFO_WIDTH-1:0] wr_phy_fifo_data,
    input  logic                      rd_phy_fifo_en,
    input  logic [PHY_FIFO_WIDTH-1:0] rd_phy_fifo_data,
    output logic                      irq
);
    localparam int LW = FIFO_AW + 1;

    logic        access;
    logic [1:0]  reg_sel;
    logic        tx_push, tx_flush, rx_pop, rx_flush, ovf_clr, ovf_set;
    logic [PHY_FIFO_WIDTH-1:0] tx_head, rx_head, hold_q;
    logic [LW-1:0] tx_level, rx_level;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic        rx_ovf;
    logic [1:0]  irq_en;
    logic [31:0] status;
    logic        unused_bits;

    assign pready      = 1'b1;
    assign unused_bits = ^{pwdata, paddr};

    // Decode the access cycle into FIFO strobes and CTRL actions.
    always_comb begin
        access   = psel && penable;
        reg_sel  = paddr[3:2];
        tx_push  = access && pwrite && (reg_sel == 2'd0);
        rx_pop   = access && !pwrite && (reg_sel == 2'd1);
        tx_flush = access && pwrite && (reg_sel == 2'd3) && pwdata[8];
        rx_flush = access && pwrite && (reg_sel == 2'd3) && pwdata[9];
        ovf_clr  = access && pwrite && (reg_sel == 2'd3) && pwdata[10];
        // A full RX FIFO drops the byte unless a same-cycle CPU pop frees a slot.
        ovf_set  = rd_phy_fifo_en && rx_full && !rx_pop && !rx_flush;
    end

    ow_fifo #(.W(PHY_FIFO_WIDTH), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_tx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (tx_flush),
        .push     (tx_push),
        .push_dat (pwdata[PHY_FIFO_WIDTH-1:0]),
        .pop      (wr_phy_fifo_en),
        .head_dat (tx_head),
        .level    (tx_level),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    ow_fifo #(.W(PHY_FIFO_WIDTH), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (rx_flush),
        .push     (rd_phy_fifo_en),
        .push_dat (rd_phy_fifo_data),
        .pop      (rx_pop),
        .head_dat (rx_head),
        .level    (rx_level),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    // Show-ahead head while data exists, otherwise hold the last presented byte.
    assign wr_phy_fifo_data = tx_empty ? hold_q : tx_head;

    // Remember the presented byte and register the empty flag from the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q            <= '0;
            wr_phy_fifo_empty <= 1'b1;
        end else begin
            hold_q            <= wr_phy_fifo_data;
            wr_phy_fifo_empty <= (tx_level == '0);
        end
    end

    // Sticky overflow flag; a new overflow beats a concurrent clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rx_ovf <= 1'b0;
        else if (ovf_set) rx_ovf <= 1'b1;
        else if (ovf_clr) rx_ovf <= 1'b0;
    end

`ifdef OW_APB_IRQ_EN
    // Interrupt enables live in CTRL[1:0]; irq is a registered level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_en <= 2'b00;
            irq    <= 1'b0;
        end else begin
            if (access && pwrite && (reg_sel == 2'd3)) irq_en <= pwdata[1:0];
            irq <= (irq_en[0] && !rx_empty) || (irq_en[1] && tx_empty) || rx_ovf;
        end
    end
`else
    assign irq_en = 2'b00;
    assign irq    = 1'b0;
`endif

    // STATUS word: flags in the low byte, zero-extended levels above.
    always_comb begin
        status = '0;
        status[0] = tx_empty;
        status[1] = tx_full;
        status[2] = rx_empty;
        status[3] = rx_full;
        status[4] = rx_ovf;
        status[8 +: LW]  = tx_level;
        status[16 +: LW] = rx_level;
    end

    // Combinational read data and error response, only during the access cycle.
    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (access) begin
            if (pwrite) begin
                // A same-cycle PHY pop frees a slot, so the write is accepted.
                if (reg_sel == 2'd0 && tx_full && !wr_phy_fifo_en) pslverr = 1'b1;
            end else begin
                case (reg_sel)
                    2'd1: begin
                        if (rx_empty) pslverr = 1'b1;
                        else          prdata[PHY_FIFO_WIDTH-1:0] = rx_head;
                    end
                    2'd2:    prdata = status;
                    2'd3:    prdata[1:0] = irq_en;
                    default: prdata = '0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ow_apb_bridge.sv
module tb_ow_apb_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [3:0]  paddr = '0;
    logic [31:0] pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        wr_phy_fifo_empty;
    logic        wr_phy_fifo_en = 1'b0;
    logic [7:0]  wr_phy_fifo_data;
    logic        rd_phy_fifo_en = 1'b0;
    logic [7:0]  rd_phy_fifo_data = '0;
    logic        irq;

    int total = 0;
    int bad   = 0;

    ow_apb_bridge dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .psel              (psel),
        .penable           (penable),
        .pwrite            (pwrite),
        .paddr             (paddr),
        .pwdata            (pwdata),
        .prdata            (prdata),
        .pready            (pready),
        .pslverr           (pslverr),
        .wr_phy_fifo_empty (wr_phy_fifo_empty),
        .wr_phy_fifo_en    (wr_phy_fifo_en),
        .wr_phy_fifo_data  (wr_phy_fifo_data),
        .rd_phy_fifo_en    (rd_phy_fifo_en),
        .rd_phy_fifo_data  (rd_phy_fifo_data),
        .irq               (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

`ifdef OW_APB_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One APB transfer; side strobes are asserted only during the access cycle.
    task automatic apb(input logic wr, input logic [3:0] addr, input logic [31:0] wd,
                       input logic tx_pop, input logic rx_push, input logic [7:0] rx_dat,
                       output logic [31:0] rd, output logic err);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        wr_phy_fifo_en = tx_pop; rd_phy_fifo_en = rx_push; rd_phy_fifo_data = rx_dat;
        #1;
        rd = prdata; err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        wr_phy_fifo_en = 1'b0; rd_phy_fifo_en = 1'b0;
    endtask

    task automatic apb_wr(input logic [3:0] addr, input logic [31:0] wd, output logic err);
        logic [31:0] d;
        apb(1'b1, addr, wd, 1'b0, 1'b0, 8'h00, d, err);
    endtask

    task automatic apb_rd(input logic [3:0] addr, output logic [31:0] rd, output logic err);
        apb(1'b0, addr, 32'h0, 1'b0, 1'b0, 8'h00, rd, err);
    endtask

    task automatic phy_pop();
        wr_phy_fifo_en = 1'b1;
        @(posedge clk); #1;
        wr_phy_fifo_en = 1'b0;
    endtask

    task automatic phy_push(input logic [7:0] d);
        rd_phy_fifo_en = 1'b1; rd_phy_fifo_data = d;
        @(posedge clk); #1;
        rd_phy_fifo_en = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        logic        any_err;
        logic [31:0] any_bad;

        // Reset values
        #12;
        check("rst_prdata", prdata, 32'h0);
        check("rst_pslverr", {31'h0, pslverr}, 32'h0);
        check("rst_tx_empty", {31'h0, wr_phy_fifo_empty}, 32'h1);
        check("rst_tx_data", {24'h0, wr_phy_fifo_data}, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_pready", {31'h0, pready}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_rd(4'h8, rd, err);
        check("rst_status", rd, 32'h0000_0005);
        check("rst_status_err", {31'h0, err}, 32'h0);

        // TX path: two bytes drained by the PHY
        apb_wr(4'h0, 32'hA5, err);
        check("tx_w1_err", {31'h0, err}, 32'h0);
        apb_wr(4'h0, 32'h3C, err);
        check("tx_head_a5", {24'h0, wr_phy_fifo_data}, 32'hA5);
        check("tx_nonempty", {31'h0, wr_phy_fifo_empty}, 32'h0);
        apb_rd(4'h8, rd, err);
        check("tx_status_lvl2", rd, 32'h0000_0204);
        phy_pop();
        check("tx_head_3c", {24'h0, wr_phy_fifo_data}, 32'h3C);
        phy_pop();
        check("tx_hold_3c", {24'h0, wr_phy_fifo_data}, 32'h3C);
        check("tx_empty_lag", {31'h0, wr_phy_fifo_empty}, 32'h0);
        apb_rd(4'h8, rd, err);
        check("tx_status_drained", rd, 32'h0000_0005);
        check("tx_empty_after", {31'h0, wr_phy_fifo_empty}, 32'h1);
        phy_pop();
        apb_rd(4'h8, rd, err);
        check("tx_pop_empty_status", rd, 32'h0000_0005);
        check("tx_pop_empty_data", {24'h0, wr_phy_fifo_data}, 32'h3C);

        // TX full: 17th write rejected
        any_err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            apb_wr(4'h0, 32'h40 + i, err);
            any_err = any_err | err;
        end
        check("tx_fill_err", {31'h0, any_err}, 32'h0);
        apb_wr(4'h0, 32'h50, err);
        check("tx_ovf_err", {31'h0, err}, 32'h1);
        apb_rd(4'h8, rd, err);
        check("tx_full_status", rd, 32'h0000_1006);
        check("tx_full_head", {24'h0, wr_phy_fifo_data}, 32'h40);
        apb(1'b1, 4'h0, 32'h60, 1'b1, 1'b0, 8'h00, rd, err);
        apb_rd(4'h8, rd, err);
        check("tx_full_pushpop_status", rd, 32'h0000_1006);
        check("tx_full_pushpop_head", {24'h0, wr_phy_fifo_data}, 32'h41);
        apb_wr(4'hC, 32'h100, err);
        apb_rd(4'h8, rd, err);
        check("tx_flush_status", rd, 32'h0000_0005);
        check("tx_flush_hold", {24'h0, wr_phy_fifo_data}, 32'h41);

        // RX path: fill, overflow, simultaneous push/pop, drain
        for (int i = 0; i < 16; i++) phy_push(8'h11 + 8'(i));
        phy_push(8'h99);
        apb_rd(4'h8, rd, err);
        check("rx_full_status", rd, 32'h0010_0019);
        apb(1'b0, 4'h4, 32'h0, 1'b0, 1'b1, 8'hAB, rd, err);
        check("rx_pushpop_data", rd, 32'h11);
        check("rx_pushpop_err", {31'h0, err}, 32'h0);
        apb_rd(4'h8, rd, err);
        check("rx_pushpop_status", rd, 32'h0010_0019);
        any_bad = 32'h0;
        for (int i = 0; i < 15; i++) begin
            apb_rd(4'h4, rd, err);
            if (rd !== 32'h12 + i || err !== 1'b0) any_bad = any_bad + 1;
        end
        check("rx_drain_mismatches", any_bad, 32'h0);
        apb_rd(4'h4, rd, err);
        check("rx_last_ab", rd, 32'hAB);
        apb_rd(4'h4, rd, err);
        check("rx_empty_read_data", rd, 32'h0);
        check("rx_empty_read_err", {31'h0, err}, 32'h1);
        apb_rd(4'h8, rd, err);
        check("rx_ovf_sticky", rd, 32'h0000_0015);
        apb_wr(4'hC, 32'h400, err);
        apb_rd(4'h8, rd, err);
        check("rx_ovf_cleared", rd, 32'h0000_0005);

        // Unmapped / ignored accesses
        apb_rd(4'h1, rd, err);
        check("unaligned_rd", rd, 32'h0);
        check("unaligned_err", {31'h0, err}, 32'h0);
        apb_wr(4'h4, 32'hFF, err);
        check("wr_rxdata_err", {31'h0, err}, 32'h0);
        apb_wr(4'h8, 32'hFFFF_FFFF, err);
        apb_rd(4'h8, rd, err);
        check("wr_ignored_status", rd, 32'h0000_0005);

        // Interrupt on RX non-empty
        apb_wr(4'hC, 32'h1, err);
        apb_rd(4'hC, rd, err);
        check("ctrl_readback", rd, {31'h0, IRQ_ON});
        phy_push(8'h77);
        check("irq_lag", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        check("irq_set", {31'h0, irq}, {31'h0, IRQ_ON});
        apb_rd(4'h4, rd, err);
        check("irq_pop_data", rd, 32'h77);
        @(posedge clk); #1;
        check("irq_clear", {31'h0, irq}, 32'h0);

        // Reset mid-stream
        apb_wr(4'h0, 32'h12, err);
        apb_wr(4'h0, 32'h34, err);
        phy_push(8'h55);
        @(posedge clk); #1;
        check("pre_rst_irq", {31'h0, irq}, {31'h0, IRQ_ON});
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        check("mid_rst_empty", {31'h0, wr_phy_fifo_empty}, 32'h1);
        check("mid_rst_data", {24'h0, wr_phy_fifo_data}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        apb_rd(4'h8, rd, err);
        check("post_rst_status", rd, 32'h0000_0005);
        apb_rd(4'hC, rd, err);
        check("post_rst_ctrl", rd, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
